cache_fill_fsm: RTL and testbench

//  Miss-handling controller for one cache, instantiated once in fetch (I-side) and once in memory (D-side).
//  On a cache miss it requests the shared memory through mem_arbitrator, then streams one block of

---
 rtl/cache_fill_fsm.sv | 104 ++++++++++
 tb/tb_cache_fill_fsm.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller: requests the shared memory port, streams one block of
// sequential word reads, writes each returned word and finally the tag.
module cache_fill_fsm #(
  parameter int BLOCK_WORDS = 8,
  parameter int ADDR_W      = 16,
  localparam int IDX_W      = $clog2(BLOCK_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic              service,
  input  logic [15:0]       memory_data,
  input  logic              memory_data_valid,
  output logic              fsm_busy,
  output logic              mem_read,
  output logic [ADDR_W-1:0] memory_address,
  output logic              write_data_array,
  output logic              write_tag_array,
  output logic [IDX_W-1:0]  word_index,
  output logic [15:0]       fill_data
);

  localparam int CNT_W = IDX_W + 1;
  localparam int OFF_W = IDX_W + 1;  // byte offset bits within a block of 16-bit words

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FILL = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  issue_cnt_reg, issue_cnt_next;
  logic [CNT_W-1:0]  recv_cnt_reg, recv_cnt_next;
  logic [ADDR_W-1:0] base_reg, base_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      issue_cnt_reg <= '0;
      recv_cnt_reg  <= '0;
      base_reg      <= '0;
    end else begin
      state_reg     <= state_next;
      issue_cnt_reg <= issue_cnt_next;
      recv_cnt_reg  <= recv_cnt_next;
      base_reg      <= base_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    issue_cnt_next   = issue_cnt_reg;
    recv_cnt_next    = recv_cnt_reg;
    base_next        = base_reg;
    mem_read         = 1'b0;
    write_data_array = 1'b0;
    write_tag_array  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (miss_detected) begin
          base_next      = {miss_address[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          issue_cnt_next = '0;
          recv_cnt_next  = '0;
          state_next     = REQ;
        end
      end
      REQ: begin
        if (service) state_next = FILL;
      end
      FILL: begin
        // Issue and receive sides advance independently so reads can be pipelined.
        if (service && (issue_cnt_reg < CNT_W'(BLOCK_WORDS))) begin
          mem_read       = 1'b1;
          issue_cnt_next = issue_cnt_reg + 1'b1;
        end
        if (memory_data_valid && (recv_cnt_reg < CNT_W'(BLOCK_WORDS))) begin
          write_data_array = 1'b1;
          recv_cnt_next    = recv_cnt_reg + 1'b1;
          if (recv_cnt_reg == CNT_W'(BLOCK_WORDS - 1)) begin
            write_tag_array = 1'b1;
            state_next      = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // A reset cycle aborts the fill at once: nothing reaches memory or the arrays.
    if (rst) begin
      mem_read         = 1'b0;
      write_data_array = 1'b0;
      write_tag_array  = 1'b0;
    end
  end

  assign fsm_busy       = (state_reg != IDLE);
  assign memory_address = rst ? '0 : base_reg + (ADDR_W'(issue_cnt_reg) << 1);
  assign word_index     = rst ? '0 : recv_cnt_reg[IDX_W-1:0];
  assign fill_data      = memory_data;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Bench for cache_fill_fsm: behavioural memory with fixed read latency plus address and
// write scoreboards; fill scenarios come from a vector table and a few hand sequences.
module tb_cache_fill_fsm;

  localparam int BW  = 8;
  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        service;
  logic [15:0] memory_data;
  logic        memory_data_valid;
  logic        fsm_busy;
  logic        mem_read;
  logic [15:0] memory_address;
  logic        write_data_array;
  logic        write_tag_array;
  logic [2:0]  word_index;
  logic [15:0] fill_data;

  always #5 clk = ~clk;

  cache_fill_fsm #(.BLOCK_WORDS(BW), .ADDR_W(16)) dut (
    .clk               (clk),
    .rst               (rst),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .service           (service),
    .memory_data       (memory_data),
    .memory_data_valid (memory_data_valid),
    .fsm_busy          (fsm_busy),
    .mem_read          (mem_read),
    .memory_address    (memory_address),
    .write_data_array  (write_data_array),
    .write_tag_array   (write_tag_array),
    .word_index        (word_index),
    .fill_data         (fill_data)
  );

  typedef struct {
    logic [15:0] miss_addr;
    logic [15:0] exp_base;
    int          mode;     // 0 service held, 1 grant delay + preempt, 2 random grant
    bit          spur;     // miss while busy, plus a stray valid after completion
  } vec_t;

  vec_t        vecs[5];
  int          total = 0;
  int          passed = 0;
  int          phase = 0;  // 0 idle, 1 waiting for grant, 2 filling
  int          issued = 0;
  int          wr_n = 0;
  logic [15:0] addr_q[$];
  logic [18:0] wr_q[$];
  logic        lat_v[LAT];
  logic [15:0] lat_d[LAT];

  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'hC3A5;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One clock: drive inputs, compare against the model, then advance memory and model.
  task automatic cycle(input logic svc, input logic miss, input logic [15:0] maddr,
                       input logic fv, input logic r);
    logic        exp_mr, exp_wr, exp_tag;
    logic [15:0] a;
    logic [18:0] w;
    @(negedge clk);
    rst               = r;
    service           = svc;
    miss_detected     = miss;
    miss_address      = maddr;
    memory_data_valid = lat_v[LAT-1] | fv;
    memory_data       = lat_v[LAT-1] ? lat_d[LAT-1] : 16'($urandom);
    #1;
    exp_mr  = !r && phase == 2 && svc && issued < BW;
    exp_wr  = !r && phase == 2 && memory_data_valid && wr_n < BW;
    exp_tag = exp_wr && wr_n == BW - 1;
    chk("fsm_busy", 32'(fsm_busy), 32'(phase != 0));
    chk("mem_read", 32'(mem_read), 32'(exp_mr));
    chk("write_data_array", 32'(write_data_array), 32'(exp_wr));
    chk("write_tag_array", 32'(write_tag_array), 32'(exp_tag));
    if (mem_read && exp_mr) begin
      if (addr_q.size() == 0) chk("unexpected_read", 32'(1), 32'(0));
      else begin
        a = addr_q.pop_front();
        chk("memory_address", 32'(memory_address), 32'(a));
        wr_q.push_back({3'(issued), mem_fn(a)});
      end
      issued++;
    end
    if (write_data_array && exp_wr) begin
      if (wr_q.size() == 0) chk("unexpected_write", 32'(1), 32'(0));
      else begin
        w = wr_q.pop_front();
        chk("word_index", 32'(word_index), 32'(w[18:16]));
        chk("fill_data", 32'(fill_data), 32'(w[15:0]));
      end
    end
    for (int i = LAT - 1; i > 0; i--) begin
      lat_v[i] = lat_v[i-1];
      lat_d[i] = lat_d[i-1];
    end
    lat_v[0] = mem_read;
    lat_d[0] = mem_fn(memory_address);
    if (exp_wr) wr_n++;
    if (r) begin
      phase = 0;
      addr_q.delete();
      wr_q.delete();
      for (int i = 0; i < LAT; i++) lat_v[i] = 1'b0;
    end else begin
      case (phase)
        0: if (miss) begin phase = 1; issued = 0; wr_n = 0; end
        1: if (svc) phase = 2;
        default: if (exp_tag) phase = 0;
      endcase
    end
  endtask

  task automatic run_fill(input logic [15:0] maddr, input logic [15:0] base,
                          input int mode, input bit spur);
    int   req_wait = 0;
    int   pause = 0;
    int   n = 0;
    logic svc;
    for (int i = 0; i < BW; i++) addr_q.push_back(base + 16'(2 * i));
    cycle(1'($urandom), 1'b1, maddr, 1'b0, 1'b0);
    while (phase != 0 && n < 300) begin
      svc = 1'b1;
      if (mode == 1) begin
        if (phase == 1 && req_wait < 5) begin svc = 1'b0; req_wait++; end
        else if (phase == 2 && issued == 3 && pause < 4) begin svc = 1'b0; pause++; end
      end else if (mode == 2) svc = ($urandom_range(0, 3) != 0);
      cycle(svc, spur, 16'h5550, 1'b0, 1'b0);
      n++;
    end
    if (phase != 0) begin
      $display("FAIL fill_timeout: got busy expected idle for miss %0h", maddr);
      total++;
      phase = 0;
    end
    chk("addr_q_drained", 32'(addr_q.size()), 32'(0));
    chk("wr_q_drained", 32'(wr_q.size()), 32'(0));
    chk("read_count", 32'(issued), 32'(BW));
    if (spur) cycle(1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
  endtask

  initial begin
    vecs[0] = '{miss_addr: 16'h1236, exp_base: 16'h1230, mode: 0, spur: 1'b0};
    vecs[1] = '{miss_addr: 16'h0A1E, exp_base: 16'h0A10, mode: 1, spur: 1'b0};
    vecs[2] = '{miss_addr: 16'hFFFA, exp_base: 16'hFFF0, mode: 0, spur: 1'b0};
    vecs[3] = '{miss_addr: 16'h3C08, exp_base: 16'h3C00, mode: 0, spur: 1'b1};
    vecs[4] = '{miss_addr: 16'h7777, exp_base: 16'h7770, mode: 2, spur: 1'b0};
    for (int i = 0; i < LAT; i++) begin lat_v[i] = 1'b0; lat_d[i] = '0; end

    rst = 1'b1; service = 1'b0; miss_detected = 1'b0; miss_address = '0;
    memory_data = '0; memory_data_valid = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 2; i++)
      cycle(1'($urandom), 1'($urandom), 16'($urandom), 1'($urandom), 1'b1);
    @(negedge clk);
    rst = 1'b0; service = 1'b0; miss_detected = 1'b0; memory_data_valid = 1'b0;
    #1;
    chk("reset_memory_address", 32'(memory_address), 32'(0));
    chk("reset_word_index", 32'(word_index), 32'(0));
    chk("reset_busy", 32'(fsm_busy), 32'(0));

    cycle(1'b1, 1'b0, 16'h0, 1'b1, 1'b0);  // stray valid while idle

    for (int v = 0; v < 5; v++) begin
      run_fill(vecs[v].miss_addr, vecs[v].exp_base, vecs[v].mode, vecs[v].spur);
      cycle(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
      $display("vector %0d miss %h base %h mode %0d: %0d/%0d so far",
               v, vecs[v].miss_addr, vecs[v].exp_base, vecs[v].mode, passed, total);
    end

    // Back-to-back: a miss in the cycle right after completion.
    run_fill(16'h2222, 16'h2220, 0, 1'b0);
    run_fill(16'h4321, 16'h4320, 0, 1'b0);
    cycle(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    $display("back-to-back fills: %0d/%0d so far", passed, total);

    // Reset in the middle of a fill after four words have been written.
    for (int i = 0; i < BW; i++) addr_q.push_back(16'h2460 + 16'(2 * i));
    cycle(1'b1, 1'b1, 16'h2468, 1'b0, 1'b0);
    for (int n = 0; n < 50 && wr_n < 4; n++) cycle(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    chk("pre_reset_writes", 32'(wr_n), 32'(4));
    cycle(1'b1, 1'b0, 16'h0, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
    run_fill(16'h0040, 16'h0040, 0, 1'b0);
    cycle(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    $display("reset mid-fill then miss 0040: %0d/%0d so far", passed, total);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
